// File: rtl/tick_sequencer_pkg.sv
// Shared constants and types for the tick sequencer and its divider.
package tick_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned PERIOD_W = 8;
  localparam int unsigned REPS_W   = 8;

  localparam logic [REPS_W-1:0] END_MARK = '0;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  // Terminal count for a period; 0 wraps to 255 so that period 0 means 256.
  function automatic logic [PERIOD_W-1:0] period_last(input logic [PERIOD_W-1:0] period);
    return period - PERIOD_W'(1);
  endfunction

endpackage

// File: rtl/tick_sequencer_if.sv
// Config, control and status bundle between the user side and the tick sequencer.
interface tick_sequencer_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned CNT_W  = 7
);

  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [7:0]        cfg_period;
  logic [7:0]        cfg_reps;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic              tick;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] step_idx;
  logic [CNT_W-1:0]  tick_count;

  modport master (
    output cfg_we, cfg_addr, cfg_period, cfg_reps, start, stop, loop_en,
    input  tick, busy, done, step_idx, tick_count
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_period, cfg_reps, start, stop, loop_en,
    output tick, busy, done, step_idx, tick_count
  );

endinterface

// File: rtl/tick_divider.sv
// Free-running 8-bit counter with synchronous clear and a terminal-count compare.
module tick_divider
  import tick_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                match_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_o = (cnt_q == period_last(period_i));

endmodule

// File: rtl/tick_sequencer.sv
// Table-driven tick scheduler: walks (period, reps) entries and emits one-cycle ticks.
module tick_sequencer
  import tick_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned CNT_W  = 7
) (
  input logic              clk,
  input logic              rst_n,
  tick_sequencer_if.slave  bus
);

  localparam logic [ADDR_W:0] DepthV = (ADDR_W+1)'(DEPTH);

  logic [PERIOD_W-1:0] period_q [DEPTH];
  logic [REPS_W-1:0]   reps_q   [DEPTH];

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   step_q, step_d;
  logic [REPS_W-1:0]   rep_q, rep_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;
  logic [PERIOD_W-1:0] act_p_q, act_p_d;
  logic [REPS_W-1:0]   act_r_q, act_r_d;

  logic                match;
  logic                tick;
  logic                div_clr;
  logic                load_en;
  logic [ADDR_W-1:0]   load_idx;
  logic [ADDR_W:0]     nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        period_q[i] <= '0;
        reps_q[i]   <= '0;
      end
    end else if (bus.cfg_we) begin
      period_q[bus.cfg_addr] <= bus.cfg_period;
      reps_q[bus.cfg_addr]   <= bus.cfg_reps;
    end
  end

  // Counter runs only in RUN; every tick, stop or non-RUN cycle restarts it at 0.
  assign div_clr = (state_q != StRun) | match | bus.stop;

  tick_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (div_clr),
    .en_i     (1'b1),
    .period_i (act_p_q),
    .match_o  (match)
  );

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    rep_d    = rep_q;
    tcnt_d   = tcnt_q;
    act_p_d  = act_p_q;
    act_r_d  = act_r_q;
    tick     = 1'b0;
    load_en  = 1'b0;
    load_idx = '0;
    nxt      = {1'b0, step_q} + (ADDR_W+1)'(1);

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.stop) begin
          if (reps_q[0] != END_MARK) begin
            state_d = StRun;
            tcnt_d  = '0;
            load_en = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (bus.stop) begin
          state_d = StIdle;
          rep_d   = '0;
        end else if (match) begin
          tick   = 1'b1;
          tcnt_d = tcnt_q + CNT_W'(1);
          if ((REPS_W+1)'(rep_q) + (REPS_W+1)'(1) < (REPS_W+1)'(act_r_q)) begin
            rep_d = rep_q + REPS_W'(1);
          end else if (nxt != DepthV && reps_q[nxt[ADDR_W-1:0]] != END_MARK) begin
            load_en  = 1'b1;
            load_idx = nxt[ADDR_W-1:0];
          end else if (bus.loop_en && reps_q[0] != END_MARK) begin
            load_en = 1'b1;
          end else begin
            state_d = StDone;
            rep_d   = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Entry load snapshots the table so later writes only land on the next load.
    if (load_en) begin
      step_d  = load_idx;
      rep_d   = '0;
      act_p_d = period_q[load_idx];
      act_r_d = reps_q[load_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= '0;
      rep_q   <= '0;
      tcnt_q  <= '0;
      act_p_q <= '0;
      act_r_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rep_q   <= rep_d;
      tcnt_q  <= tcnt_d;
      act_p_q <= act_p_d;
      act_r_q <= act_r_d;
    end
  end

  assign bus.tick       = tick;
  assign bus.busy       = (state_q == StRun);
  assign bus.done       = (state_q == StDone);
  assign bus.step_idx   = step_q;
  assign bus.tick_count = tcnt_q;

endmodule

// File: doc/tick_sequencer.md
Name: tick_sequencer

Overview:
- Programmable tick scheduler. Runs a small table of (period, repeat) entries through an internal divider and emits one-cycle ticks.
- Each entry produces `reps` ticks spaced `period` cycles apart, then the block advances to the next entry. At the end of the table it either stops or loops.
- Sits between the user switch/config interface and the pulse-consuming logic. It sequences the counter/compare divider datapath used in this design.

Parameters:
- DEPTH, 4, number of table entries (power of two, 2..16)
- ADDR_W, 2, log2(DEPTH)
- CNT_W, 7, width of wrapping tick counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  table write strobe
- cfg_addr  in  ADDR_W  entry written
- cfg_period  in  8  period in cycles; 0 means 256
- cfg_reps  in  8  ticks for this entry; 0 marks end of table
- start  in  1  begin sequence from entry 0 (level sampled)
- stop  in  1  abort sequence
- loop_en  in  1  wrap to entry 0 at end of table
- tick  out  1  one-cycle pulse
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on normal completion
- step_idx  out  ADDR_W  active entry index
- tick_count  out  CNT_W  ticks issued since last accepted start, wraps

Behaviour:
- Reset (async, rst_n=0): all table entries 0/0, state IDLE, all counters 0, all outputs 0. Takes effect immediately, including mid-run.
- Table write: on clk edge when cfg_we=1. Allowed in any state.
  - The active entry's period/reps are latched into active registers at entry load.
  - A write to the active entry does not affect it until it is next loaded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and stop=0 and entry0.reps!=0 → RUN. Load entry 0: div_cnt=0, rep_cnt=0, step_idx=0, tick_count=0.
  - start=1 and entry0.reps==0 → DONE; busy never asserts.
  - start and stop together: stop wins, stay IDLE.
- RUN:
  - P_eff = period, or 256 when period=0. R_eff = reps.
  - div_cnt increments each cycle.
  - match = (div_cnt == P_eff-1), compared in 8 bits; period 0 compares to 255.
  - tick = RUN & match & !stop (combinational from registers and stop).
  - The first tick of an entry falls on the P_eff-th cycle after the entry load.
  - On tick: div_cnt←0, tick_count←tick_count+1 (wraps 127→0).
    - If rep_cnt < R_eff-1: rep_cnt++.
    - Else advance to nxt=step_idx+1.
      - If nxt==DEPTH or table[nxt].reps==0: end of table.
      - Otherwise load nxt.
  - End of table:
    - loop_en=1 and entry0.reps!=0 → load entry 0, stay RUN, no done.
    - Otherwise → DONE.
  - stop=1 → IDLE next edge, tick suppressed that cycle, no done, div_cnt/rep_cnt cleared. step_idx and tick_count hold.
  - start in RUN: ignored.
- DONE: done=1 for exactly one cycle, then IDLE. start during DONE is ignored.
- Outputs:
  - busy = (state==RUN), decoded from the registered state.
  - done = (state==DONE).
- No back-to-back gap between entries: the next entry's div_cnt starts at 0 on the cycle after the last tick.

Decomposition:
- Shared package/include holds:
  - state encoding localparams ST_IDLE=0, ST_RUN=1, ST_DONE=2
  - PERIOD_W=8, REPS_W=8
  - the END_MARK=0 reps constant
- One sub-module: tick_divider.
  - Contents: 8-bit counter, clear, enable, period input, match output.
  - It reuses the counter/compare datapath style.
  - The FSM, table and rep counting stay in tick_sequencer.

Test Plan:
- Basic sequence:
  - Setup: table {P=3,R=2},{P=5,R=1}, rest reps 0; loop_en=0; start pulse. Cycle 0 = first cycle after the start edge.
  - Ticks at cycles 2, 5, 10. step_idx=1 from cycle 6. done at cycle 11. busy high cycles 0–10. tick_count=3.
- Period 0 means 256:
  - Setup: entry0 {P=0,R=2}.
  - Ticks at cycles 255 and 511, done at 512.
- Loop and counter wrap:
  - Setup: entry0 {P=1,R=3}, entry1 reps=0, loop_en=1.
  - tick high every cycle, busy stays high, step_idx=0, no done.
  - tick_count reads 127 after the 127th tick and 0 after the 128th.
- Stop coincident with tick:
  - Setup: {P=4,R=5}; stop asserted at cycle 3 (match cycle).
  - tick stays 0 at cycle 3, busy low from cycle 4, done never pulses, tick_count unchanged.
- Write to active entry:
  - Setup: {P=4,R=2} with loop_en=1; write entry0 P=2 at cycle 1.
  - Ticks at 3 and 7, then at 9, 11.
- Reset and empty table:
  - rst_n low at cycle 6 of a run: busy/tick/step_idx clear without a clock edge, and the table is cleared.
  - After release, a start pulse gives done one cycle later with busy never high.
